hack_led_io: RTL

//  Memory-mapped LED output peripheral for the Hack CPU data bus; it generalises the fixed 2-LED tap of inM.

---
 rtl/hack_led_io_pkg.sv | 18 +
 rtl/hack_led_io_if.sv | 11 +
 rtl/hack_led_io_led_pwm_channel.sv | 30 +++
 rtl/hack_led_io.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/hack_led_io_pkg.sv
// Register map offsets, DUTY width and decode selector shared by the LED peripheral files.
package hack_io_pkg;

  localparam int unsigned OFF_ON   = 0;
  localparam int unsigned OFF_MODE = 1;
  localparam int unsigned OFF_BDIV = 2;
  localparam int unsigned OFF_DUTY = 3;
  localparam int unsigned DUTY_W   = 8;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_ON,
    SEL_MODE,
    SEL_BDIV,
    SEL_DUTY
  } reg_sel_e;

endpackage

// File: rtl/hack_led_io_if.sv
// Hack CPU data-bus slice seen by the LED peripheral: address/data/strobe in, read-back out.
interface hack_led_io_if;
  logic [15:0] addressM;
  logic [15:0] outM;
  logic        writeM;
  logic [15:0] rd_data;
  logic        rd_hit;

  modport master (output addressM, outM, writeM, input rd_data, rd_hit);
  modport slave  (input addressM, outM, writeM, output rd_data, rd_hit);
endinterface

// File: rtl/hack_led_io_led_pwm_channel.sv
// One LED brightness channel: stores DUTY and compares it against the shared PWM counter.
module led_pwm_channel
  import hack_io_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [DUTY_W-1:0] wdata,
  input  logic [DUTY_W-1:0] pwm_cnt,
  output logic [DUTY_W-1:0] duty,
  output logic              gate
);

  logic [DUTY_W-1:0] duty_q, duty_d;

  always_comb begin
    duty_d = duty_q;
    if (we) duty_d = wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) duty_q <= '1;
    else       duty_q <= duty_d;
  end

  // Full-scale duty must stay lit through pwm_cnt==255, which the compare alone misses.
  assign gate = (duty_q == '1) | (pwm_cnt < duty_q);
  assign duty = duty_q;

endmodule

// File: rtl/hack_led_io.sv
// Memory-mapped LED output peripheral for the Hack data bus (on/off, blink, optional PWM).
// Optional PWM brightness is built when HACK_LED_PWM_EN is defined.
module hack_led_io
  import hack_io_pkg::*;
#(
  parameter int unsigned N_LEDS        = 2,
  parameter logic [15:0] BASE_ADDR     = 16'h6001,
  parameter int unsigned PRESC_DIV     = 25000,
  parameter logic [15:0] BLINK_DIV_RST = 16'd499
) (
  input  logic              clk,
  input  logic              reset,
  hack_led_io_if.slave      bus,
  output logic [N_LEDS-1:0] leds
);

`ifdef HACK_LED_PWM_EN
  localparam int unsigned WIN = OFF_DUTY + N_LEDS;
`else
  localparam int unsigned WIN = OFF_DUTY;
`endif
  localparam int unsigned          PRESC_W    = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam logic [PRESC_W-1:0]   PRESC_LAST = PRESC_W'(PRESC_DIV - 1);

  logic [15:0]        offset;
  reg_sel_e           sel;
  logic [15:0]        rd;
  logic [N_LEDS-1:0]  gate;
  logic               tick;

  logic [N_LEDS-1:0]  on_q, on_d, mode_q, mode_d, leds_q, leds_d;
  logic [15:0]        bdiv_q, bdiv_d, bcnt_q, bcnt_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               phase_q, phase_d;

  // Wrapping subtraction keeps addresses below BASE_ADDR far outside the window.
  assign offset = bus.addressM - BASE_ADDR;

  always_comb begin
    sel = SEL_NONE;
    if      (offset == 16'(OFF_ON))   sel = SEL_ON;
    else if (offset == 16'(OFF_MODE)) sel = SEL_MODE;
    else if (offset == 16'(OFF_BDIV)) sel = SEL_BDIV;
    else if (offset < 16'(WIN))       sel = SEL_DUTY;
  end

`ifdef HACK_LED_PWM_EN
  logic [DUTY_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [DUTY_W-1:0] duty_rd [N_LEDS];

  always_comb pwm_cnt_d = pwm_cnt_q + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pwm_cnt_q <= '0;
    else       pwm_cnt_q <= pwm_cnt_d;
  end

  for (genvar g = 0; g < N_LEDS; g++) begin : g_ch
    led_pwm_channel u_ch (
      .clk     (clk),
      .reset   (reset),
      .we      (bus.writeM && (sel == SEL_DUTY) && (offset == 16'(OFF_DUTY + g))),
      .wdata   (bus.outM[DUTY_W-1:0]),
      .pwm_cnt (pwm_cnt_q),
      .duty    (duty_rd[g]),
      .gate    (gate[g])
    );
  end
`else
  assign gate = '1;
`endif

  always_comb begin
    rd = '0;
    case (sel)
      SEL_ON:   rd = 16'(on_q);
      SEL_MODE: rd = 16'(mode_q);
      SEL_BDIV: rd = bdiv_q;
`ifdef HACK_LED_PWM_EN
      SEL_DUTY: begin
        for (int unsigned i = 0; i < N_LEDS; i++)
          if (offset == 16'(OFF_DUTY + i)) rd = 16'(duty_rd[i]);
      end
`endif
      default:  rd = '0;
    endcase
  end

  assign bus.rd_data = rd;
  assign bus.rd_hit  = (sel != SEL_NONE);
  assign tick        = (presc_q == PRESC_LAST);

  always_comb begin
    on_d    = on_q;
    mode_d  = mode_q;
    bdiv_d  = bdiv_q;
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    presc_d = tick ? '0 : presc_q + 1'b1;

    if (bus.writeM && sel == SEL_ON)   on_d   = bus.outM[N_LEDS-1:0];
    if (bus.writeM && sel == SEL_MODE) mode_d = bus.outM[N_LEDS-1:0];

    if (tick) begin
      if (bcnt_q == bdiv_q) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d  = bcnt_q + 1'b1;
      end
    end
    // A divider write restarts the blink sequence and wins over a coincident tick.
    if (bus.writeM && sel == SEL_BDIV) begin
      bdiv_d  = bus.outM;
      bcnt_d  = '0;
      phase_d = 1'b0;
    end

    leds_d = on_q & ((mode_q & {N_LEDS{phase_q}}) | ~mode_q) & gate;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      on_q    <= '0;
      mode_q  <= '0;
      bdiv_q  <= BLINK_DIV_RST;
      bcnt_q  <= '0;
      phase_q <= 1'b0;
      presc_q <= '0;
      leds_q  <= '0;
    end else begin
      on_q    <= on_d;
      mode_q  <= mode_d;
      bdiv_q  <= bdiv_d;
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
      presc_q <= presc_d;
      leds_q  <= leds_d;
    end
  end

  assign leds = leds_q;

endmodule
